axi_mem_arbiter: RTL and testbench
==================================

# axi_mem_arbiter

Two-master, single-slave AXI4 arbiter sharing the one memory port between the instruction fetch unit (master 0, read-only) and the load/store unit (master 1, read and write). One transaction at a time: grants a master, forwards its address, data and response channels combinationally to the slave, and releases the bus on the final response handshake. Sits between the core's fetch/load-store units and the memory/SRAM slave.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, data width (strobe width DATA_W/8)
- ID_W, 4, transaction id width

Ports (`<p>` = m0, m1 or s; m-ports take the direction shown, s-ports the opposite; payloads unchanged):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on clk rising edge
- `<p>`_arvalid/arready  in/out  1  read address handshake (m0, m1, s)
- `<p>`_araddr, _arid, _arlen, _arsize, _arburst  in  ADDR_W, ID_W, 8, 3, 2  read address payload (m0, m1, s)
- `<p>`_rvalid/rready  out/in  1  read data handshake (m0, m1, s)
- `<p>`_rdata, _rresp, _rlast, _rid  out  DATA_W, 2, 1, ID_W  read data payload (m0, m1, s)
- `<p>`_awvalid/awready, _awaddr, _awid, _awlen, _awsize, _awburst  in/out, in  1, ADDR_W, ID_W, 8, 3, 2  write address (m1, s only)
- `<p>`_wvalid/wready, _wdata, _wstrb, _wlast  in/out, in  1, DATA_W, DATA_W/8, 1  write data (m1, s only)
- `<p>`_bvalid/bready, _bresp, _bid  out/in, out  1, 2, ID_W  write response (m1, s only)

## Operation
- States: IDLE, AR0, R0, AR1, R1, AW, W, B. Register last_grant (0 = m0, 1 = m1).
- IDLE: requests are m0_arvalid, m1_arvalid, m1_awvalid. m1_awvalid has priority over m1_arvalid. Between m0 and m1 requests, grant the master not equal to last_grant. Next state AR0, AR1 or AW; last_grant updates on the grant.
- AR*: connect granted master's AR to the slave. On s_arvalid&s_arready, go to R*.
- R*: connect slave R to the granted master. On s_rvalid&s_rready&s_rlast, go to IDLE.
- AW: connect m1 AW. On handshake, go to W.
- W: connect m1 W. On s_wvalid&s_wready&s_wlast, go to B.
- B: connect slave B to m1. On s_bvalid&s_bready, go to IDLE.
- Ungranted channels: master-side ready/valid outputs 0, slave-side valid outputs 0, slave-side ready outputs 0. Payload outputs are don't-care when the matching valid is 0; drive them from m1.
- Slave response arriving outside R*/B is not acknowledged.
- Ids, len, burst and strobes pass through unmodified. No reordering; at most one outstanding transaction.

## Timing
- Reset: state IDLE, last_grant=0, every valid and ready output 0.
- Grant latency: request seen in IDLE at edge N; forwarding begins in cycle N+1. The master's valid must stay high, per AXI.
- Forwarding is combinational within a state: zero added latency per beat, and the full slave throughput is preserved.
- Return to IDLE is registered: one idle cycle between consecutive transactions. Back-to-back transactions from the same master therefore take at least one bubble cycle.
- A request that drops in the same cycle as the IDLE grant still enters AR*/AW. The bench treats this as a master protocol violation.
- rst_n low mid-transaction: the arbiter returns to IDLE at the next edge. The slave must be reset concurrently; no recovery is provided.

## Structure
- Shared package (e.g. `axi_pkg`): state encoding enum; AXI burst and resp constants (INCR=2'b01, OKAY=2'b00); default size/len.
- One register block: state plus last_grant. Per-channel muxing is combinational in the same module.
- Sub-module `axi_rr_pick` (2-way round-robin pick) is natural and reusable.

## Test plan
- m0 read alone, araddr=0x8000_0000, arlen=1, slave returns 2 beats -> m0 sees both beats; s_arvalid rises 1 cycle after m0_arvalid; state back to IDLE after the rlast beat.
- m0_arvalid and m1_arvalid together after reset -> m1 granted first (last_grant=0), then m0. A second tie grants m1 again only after m0 was served.
- m1 write, awaddr=0x8000_0010, 2 W beats with wstrb=0x0F, bresp=OKAY -> sequence AW, W, B, IDLE; m0_arready stays 0 throughout.
- m1_awvalid and m1_arvalid together -> write served first, then read.
- Slave stalls s_rvalid 5 cycles -> no beat is lost or duplicated; the ungranted master's ready/valid stay 0.
- rst_n low during R1 -> next cycle all valid/ready outputs 0, state IDLE; a fresh m0 read then completes normally.

Source files
------------

// File: rtl/axi_mem_arbiter_pkg.sv
// rtl/axi_mem_arbiter_pkg.sv - shared types and AXI constants for the two-master memory arbiter
package axi_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR0  = 3'd1,
        ST_R0   = 3'd2,
        ST_AR1  = 3'd3,
        ST_R1   = 3'd4,
        ST_AW   = 3'd5,
        ST_W    = 3'd6,
        ST_B    = 3'd7
    } arb_state_t;

    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [2:0] SIZE_DEFAULT = 3'd3;
    localparam logic [7:0] LEN_DEFAULT  = 8'd0;

endpackage

// File: rtl/axi_rr_pick.sv
// rtl/axi_rr_pick.sv - two-way round-robin pick; on a tie the requester not granted last wins
module axi_rr_pick (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_idx
);

    always_comb begin
        o_valid = |i_req;
        if (&i_req) begin
            o_idx = ~i_last;
        end else begin
            o_idx = i_req[1];
        end
    end

endmodule

// File: rtl/axi_mem_arbiter.sv
// rtl/axi_mem_arbiter.sv - shares one AXI4 slave port between fetch (m0, read) and load/store (m1, read/write)
module axi_mem_arbiter
    import axi_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    // m0 read
    input  logic                i_m0_arvalid,
    output logic                o_m0_arready,
    input  logic [ADDR_W-1:0]   i_m0_araddr,
    input  logic [ID_W-1:0]     i_m0_arid,
    input  logic [7:0]          i_m0_arlen,
    input  logic [2:0]          i_m0_arsize,
    input  logic [1:0]          i_m0_arburst,
    output logic                o_m0_rvalid,
    input  logic                i_m0_rready,
    output logic [DATA_W-1:0]   o_m0_rdata,
    output logic [1:0]          o_m0_rresp,
    output logic                o_m0_rlast,
    output logic [ID_W-1:0]     o_m0_rid,
    // m1 read
    input  logic                i_m1_arvalid,
    output logic                o_m1_arready,
    input  logic [ADDR_W-1:0]   i_m1_araddr,
    input  logic [ID_W-1:0]     i_m1_arid,
    input  logic [7:0]          i_m1_arlen,
    input  logic [2:0]          i_m1_arsize,
    input  logic [1:0]          i_m1_arburst,
    output logic                o_m1_rvalid,
    input  logic                i_m1_rready,
    output logic [DATA_W-1:0]   o_m1_rdata,
    output logic [1:0]          o_m1_rresp,
    output logic                o_m1_rlast,
    output logic [ID_W-1:0]     o_m1_rid,
    // m1 write
    input  logic                i_m1_awvalid,
    output logic                o_m1_awready,
    input  logic [ADDR_W-1:0]   i_m1_awaddr,
    input  logic [ID_W-1:0]     i_m1_awid,
    input  logic [7:0]          i_m1_awlen,
    input  logic [2:0]          i_m1_awsize,
    input  logic [1:0]          i_m1_awburst,
    input  logic                i_m1_wvalid,
    output logic                o_m1_wready,
    input  logic [DATA_W-1:0]   i_m1_wdata,
    input  logic [DATA_W/8-1:0] i_m1_wstrb,
    input  logic                i_m1_wlast,
    output logic                o_m1_bvalid,
    input  logic                i_m1_bready,
    output logic [1:0]          o_m1_bresp,
    output logic [ID_W-1:0]     o_m1_bid,
    // slave
    output logic                o_s_arvalid,
    input  logic                i_s_arready,
    output logic [ADDR_W-1:0]   o_s_araddr,
    output logic [ID_W-1:0]     o_s_arid,
    output logic [7:0]          o_s_arlen,
    output logic [2:0]          o_s_arsize,
    output logic [1:0]          o_s_arburst,
    input  logic                i_s_rvalid,
    output logic                o_s_rready,
    input  logic [DATA_W-1:0]   i_s_rdata,
    input  logic [1:0]          i_s_rresp,
    input  logic                i_s_rlast,
    input  logic [ID_W-1:0]     i_s_rid,
    output logic                o_s_awvalid,
    input  logic                i_s_awready,
    output logic [ADDR_W-1:0]   o_s_awaddr,
    output logic [ID_W-1:0]     o_s_awid,
    output logic [7:0]          o_s_awlen,
    output logic [2:0]          o_s_awsize,
    output logic [1:0]          o_s_awburst,
    output logic                o_s_wvalid,
    input  logic                i_s_wready,
    output logic [DATA_W-1:0]   o_s_wdata,
    output logic [DATA_W/8-1:0] o_s_wstrb,
    output logic                o_s_wlast,
    input  logic                i_s_bvalid,
    output logic                o_s_bready,
    input  logic [1:0]          i_s_bresp,
    input  logic [ID_W-1:0]     i_s_bid
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_last_grant;
    logic       w_pick_valid;
    logic       w_pick_idx;
    logic       w_sel_m0;

    axi_rr_pick u_pick (
        .i_req   ({i_m1_arvalid | i_m1_awvalid, i_m0_arvalid}),
        .i_last  (r_last_grant),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_pick_valid) begin
                r_last_grant <= w_pick_idx;
            end
        end
    end

    // Slave-side payloads follow m1 unless m0 owns the AR channel.
    assign w_sel_m0    = (r_state == ST_AR0);
    assign o_s_araddr  = w_sel_m0 ? i_m0_araddr  : i_m1_araddr;
    assign o_s_arid    = w_sel_m0 ? i_m0_arid    : i_m1_arid;
    assign o_s_arlen   = w_sel_m0 ? i_m0_arlen   : i_m1_arlen;
    assign o_s_arsize  = w_sel_m0 ? i_m0_arsize  : i_m1_arsize;
    assign o_s_arburst = w_sel_m0 ? i_m0_arburst : i_m1_arburst;
    assign o_s_awaddr  = i_m1_awaddr;
    assign o_s_awid    = i_m1_awid;
    assign o_s_awlen   = i_m1_awlen;
    assign o_s_awsize  = i_m1_awsize;
    assign o_s_awburst = i_m1_awburst;
    assign o_s_wdata   = i_m1_wdata;
    assign o_s_wstrb   = i_m1_wstrb;
    assign o_s_wlast   = i_m1_wlast;
    assign o_m0_rdata  = i_s_rdata;
    assign o_m0_rresp  = i_s_rresp;
    assign o_m0_rlast  = i_s_rlast;
    assign o_m0_rid    = i_s_rid;
    assign o_m1_rdata  = i_s_rdata;
    assign o_m1_rresp  = i_s_rresp;
    assign o_m1_rlast  = i_s_rlast;
    assign o_m1_rid    = i_s_rid;
    assign o_m1_bresp  = i_s_bresp;
    assign o_m1_bid    = i_s_bid;

    always_comb begin
        w_state_nxt  = r_state;
        o_m0_arready = 1'b0;
        o_m0_rvalid  = 1'b0;
        o_m1_arready = 1'b0;
        o_m1_rvalid  = 1'b0;
        o_m1_awready = 1'b0;
        o_m1_wready  = 1'b0;
        o_m1_bvalid  = 1'b0;
        o_s_arvalid  = 1'b0;
        o_s_rready   = 1'b0;
        o_s_awvalid  = 1'b0;
        o_s_wvalid   = 1'b0;
        o_s_bready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    if (!w_pick_idx)       w_state_nxt = ST_AR0;
                    else if (i_m1_awvalid) w_state_nxt = ST_AW;
                    else                   w_state_nxt = ST_AR1;
                end
            end
            ST_AR0: begin
                o_s_arvalid  = i_m0_arvalid;
                o_m0_arready = i_s_arready;
                if (i_m0_arvalid && i_s_arready) w_state_nxt = ST_R0;
            end
            ST_R0: begin
                o_m0_rvalid = i_s_rvalid;
                o_s_rready  = i_m0_rready;
                if (i_s_rvalid && i_m0_rready && i_s_rlast) w_state_nxt = ST_IDLE;
            end
            ST_AR1: begin
                o_s_arvalid  = i_m1_arvalid;
                o_m1_arready = i_s_arready;
                if (i_m1_arvalid && i_s_arready) w_state_nxt = ST_R1;
            end
            ST_R1: begin
                o_m1_rvalid = i_s_rvalid;
                o_s_rready  = i_m1_rready;
                if (i_s_rvalid && i_m1_rready && i_s_rlast) w_state_nxt = ST_IDLE;
            end
            ST_AW: begin
                o_s_awvalid  = i_m1_awvalid;
                o_m1_awready = i_s_awready;
                if (i_m1_awvalid && i_s_awready) w_state_nxt = ST_W;
            end
            ST_W: begin
                o_s_wvalid  = i_m1_wvalid;
                o_m1_wready = i_s_wready;
                if (i_m1_wvalid && i_s_wready && i_m1_wlast) w_state_nxt = ST_B;
            end
            ST_B: begin
                o_m1_bvalid = i_s_bvalid;
                o_s_bready  = i_m1_bready;
                if (i_s_bvalid && i_m1_bready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb/tb_axi_mem_arbiter.sv - directed self-checking bench for axi_mem_arbiter
module tb_axi_mem_arbiter;
    import axi_mem_arbiter_pkg::*;

    logic        clk, rst_n;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
    logic [31:0] m0_araddr;
    logic [3:0]  m0_arid, m0_rid;
    logic [7:0]  m0_arlen;
    logic [2:0]  m0_arsize;
    logic [1:0]  m0_arburst, m0_rresp;
    logic [63:0] m0_rdata;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
    logic [31:0] m1_araddr, m1_awaddr;
    logic [3:0]  m1_arid, m1_rid, m1_awid, m1_bid;
    logic [7:0]  m1_arlen, m1_awlen, m1_wstrb;
    logic [2:0]  m1_arsize, m1_awsize;
    logic [1:0]  m1_arburst, m1_rresp, m1_awburst, m1_bresp;
    logic [63:0] m1_rdata, m1_wdata;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [31:0] s_araddr, s_awaddr;
    logic [3:0]  s_arid, s_rid, s_awid, s_bid;
    logic [7:0]  s_arlen, s_awlen, s_wstrb;
    logic [2:0]  s_arsize, s_awsize;
    logic [1:0]  s_arburst, s_rresp, s_awburst, s_bresp;
    logic [63:0] s_rdata, s_wdata;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;

    int n_checks = 0;
    int n_errors = 0;

    wire any_out = m0_arready | m0_rvalid | m1_arready | m1_rvalid | m1_awready | m1_wready |
                   m1_bvalid | s_arvalid | s_rready | s_awvalid | s_wvalid | s_bready;

    axi_mem_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_arvalid(m0_arvalid), .o_m0_arready(m0_arready), .i_m0_araddr(m0_araddr),
        .i_m0_arid(m0_arid), .i_m0_arlen(m0_arlen), .i_m0_arsize(m0_arsize), .i_m0_arburst(m0_arburst),
        .o_m0_rvalid(m0_rvalid), .i_m0_rready(m0_rready), .o_m0_rdata(m0_rdata), .o_m0_rresp(m0_rresp),
        .o_m0_rlast(m0_rlast), .o_m0_rid(m0_rid),
        .i_m1_arvalid(m1_arvalid), .o_m1_arready(m1_arready), .i_m1_araddr(m1_araddr),
        .i_m1_arid(m1_arid), .i_m1_arlen(m1_arlen), .i_m1_arsize(m1_arsize), .i_m1_arburst(m1_arburst),
        .o_m1_rvalid(m1_rvalid), .i_m1_rready(m1_rready), .o_m1_rdata(m1_rdata), .o_m1_rresp(m1_rresp),
        .o_m1_rlast(m1_rlast), .o_m1_rid(m1_rid),
        .i_m1_awvalid(m1_awvalid), .o_m1_awready(m1_awready), .i_m1_awaddr(m1_awaddr), .i_m1_awid(m1_awid),
        .i_m1_awlen(m1_awlen), .i_m1_awsize(m1_awsize), .i_m1_awburst(m1_awburst),
        .i_m1_wvalid(m1_wvalid), .o_m1_wready(m1_wready), .i_m1_wdata(m1_wdata), .i_m1_wstrb(m1_wstrb),
        .i_m1_wlast(m1_wlast), .o_m1_bvalid(m1_bvalid), .i_m1_bready(m1_bready), .o_m1_bresp(m1_bresp),
        .o_m1_bid(m1_bid),
        .o_s_arvalid(s_arvalid), .i_s_arready(s_arready), .o_s_araddr(s_araddr), .o_s_arid(s_arid),
        .o_s_arlen(s_arlen), .o_s_arsize(s_arsize), .o_s_arburst(s_arburst),
        .i_s_rvalid(s_rvalid), .o_s_rready(s_rready), .i_s_rdata(s_rdata), .i_s_rresp(s_rresp),
        .i_s_rlast(s_rlast), .i_s_rid(s_rid),
        .o_s_awvalid(s_awvalid), .i_s_awready(s_awready), .o_s_awaddr(s_awaddr), .o_s_awid(s_awid),
        .o_s_awlen(s_awlen), .o_s_awsize(s_awsize), .o_s_awburst(s_awburst),
        .o_s_wvalid(s_wvalid), .i_s_wready(s_wready), .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb),
        .o_s_wlast(s_wlast), .i_s_bvalid(s_bvalid), .o_s_bready(s_bready), .i_s_bresp(s_bresp),
        .i_s_bid(s_bid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_arvalid = 0; m0_araddr = '0; m0_arid = '0; m0_arlen = '0; m0_arsize = 3'd3; m0_arburst = BURST_INCR;
        m0_rready = 0;
        m1_arvalid = 0; m1_araddr = '0; m1_arid = '0; m1_arlen = '0; m1_arsize = 3'd3; m1_arburst = BURST_INCR;
        m1_rready = 0;
        m1_awvalid = 0; m1_awaddr = '0; m1_awid = '0; m1_awlen = '0; m1_awsize = 3'd3; m1_awburst = BURST_INCR;
        m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 0; m1_bready = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = RESP_OKAY; s_rlast = 0; s_rid = '0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = RESP_OKAY; s_bid = '0;
    endtask

    // Full read by master m; caller guarantees the arbiter is IDLE and m wins the pick.
    task automatic do_read(input int m, input logic [31:0] addr, input logic [3:0] id, input int beats, input int stall);
        logic       got_v, oth_v;
        logic [63:0] got_d;
        logic [63:0] exp_d;
        if (m == 0) begin
            m0_arvalid = 1; m0_araddr = addr; m0_arid = id; m0_arlen = 8'(beats - 1); m0_rready = 1;
        end else begin
            m1_arvalid = 1; m1_araddr = addr; m1_arid = id; m1_arlen = 8'(beats - 1); m1_rready = 1;
        end
        #1;
        n_checks++; if (s_arvalid !== 1'b0) begin n_errors++; $display("FAIL rd_idle_s_arvalid got=%b exp=0", s_arvalid); end
        clk_step();
        n_checks++;
        if ((m == 0 && dut.r_state !== ST_AR0) || (m == 1 && dut.r_state !== ST_AR1)) begin
            n_errors++; $display("FAIL rd_grant m=%0d state=%0d", m, dut.r_state);
        end
        n_checks++; if (s_arvalid !== 1'b1) begin n_errors++; $display("FAIL rd_s_arvalid got=%b exp=1", s_arvalid); end
        n_checks++; if (s_araddr !== addr) begin n_errors++; $display("FAIL rd_s_araddr got=%h exp=%h", s_araddr, addr); end
        n_checks++; if (s_arid !== id) begin n_errors++; $display("FAIL rd_s_arid got=%h exp=%h", s_arid, id); end
        n_checks++; if (s_arlen !== 8'(beats - 1)) begin n_errors++; $display("FAIL rd_s_arlen got=%0d exp=%0d", s_arlen, beats - 1); end
        n_checks++; if (s_arburst !== BURST_INCR) begin n_errors++; $display("FAIL rd_s_arburst got=%b exp=01", s_arburst); end
        s_arready = 1;
        #1;
        got_v = (m == 0) ? m0_arready : m1_arready;
        oth_v = (m == 0) ? m1_arready : m0_arready;
        n_checks++; if (got_v !== 1'b1 || oth_v !== 1'b0) begin n_errors++; $display("FAIL rd_arready got=%b/%b exp=1/0", got_v, oth_v); end
        clk_step();
        s_arready = 0;
        if (m == 0) m0_arvalid = 0; else m1_arvalid = 0;
        for (int b = 0; b < beats; b++) begin
            if (b == 0) begin
                for (int s = 0; s < stall; s++) begin
                    #1;
                    n_checks++;
                    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m0_arready !== 1'b0 || m1_arready !== 1'b0) begin
                        n_errors++; $display("FAIL rd_stall_quiet rv=%b%b ar=%b%b exp=00/00", m0_rvalid, m1_rvalid, m0_arready, m1_arready);
                    end
                    clk_step();
                end
            end
            exp_d = {addr, 32'(b)};
            s_rvalid = 1; s_rdata = exp_d; s_rlast = (b == beats - 1); s_rid = id;
            #1;
            got_v = (m == 0) ? m0_rvalid : m1_rvalid;
            oth_v = (m == 0) ? m1_rvalid : m0_rvalid;
            got_d = (m == 0) ? m0_rdata : m1_rdata;
            n_checks++; if (got_v !== 1'b1 || oth_v !== 1'b0) begin n_errors++; $display("FAIL rd_rvalid beat=%0d got=%b/%b exp=1/0", b, got_v, oth_v); end
            n_checks++; if (got_d !== exp_d) begin n_errors++; $display("FAIL rd_rdata beat=%0d got=%h exp=%h", b, got_d, exp_d); end
            n_checks++; if (s_rready !== 1'b1) begin n_errors++; $display("FAIL rd_s_rready beat=%0d got=%b exp=1", b, s_rready); end
            clk_step();
        end
        s_rvalid = 0; s_rlast = 0;
        if (m == 0) m0_rready = 0; else m1_rready = 0;
        n_checks++; if (dut.r_state !== ST_IDLE) begin n_errors++; $display("FAIL rd_done_idle state=%0d exp=%0d", dut.r_state, ST_IDLE); end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input int beats, input logic [7:0] strb);
        m1_awvalid = 1; m1_awaddr = addr; m1_awid = id; m1_awlen = 8'(beats - 1);
        #1;
        n_checks++; if (s_awvalid !== 1'b0) begin n_errors++; $display("FAIL wr_idle_s_awvalid got=%b exp=0", s_awvalid); end
        clk_step();
        n_checks++; if (dut.r_state !== ST_AW) begin n_errors++; $display("FAIL wr_state_aw got=%0d exp=%0d", dut.r_state, ST_AW); end
        n_checks++; if (s_awvalid !== 1'b1 || s_awaddr !== addr || s_awid !== id) begin
            n_errors++; $display("FAIL wr_aw_fwd got=%b/%h/%h exp=1/%h/%h", s_awvalid, s_awaddr, s_awid, addr, id);
        end
        n_checks++; if (s_arvalid !== 1'b0) begin n_errors++; $display("FAIL wr_aw_s_arvalid got=%b exp=0", s_arvalid); end
        s_awready = 1;
        #1;
        n_checks++; if (m1_awready !== 1'b1) begin n_errors++; $display("FAIL wr_awready got=%b exp=1", m1_awready); end
        clk_step();
        s_awready = 0; m1_awvalid = 0;
        n_checks++; if (dut.r_state !== ST_W) begin n_errors++; $display("FAIL wr_state_w got=%0d exp=%0d", dut.r_state, ST_W); end
        for (int b = 0; b < beats; b++) begin
            m1_wvalid = 1; m1_wdata = {32'hC0DE_0000, 32'(b)}; m1_wstrb = strb; m1_wlast = (b == beats - 1);
            s_wready = 1;
            #1;
            n_checks++; if (s_wvalid !== 1'b1 || s_wdata !== {32'hC0DE_0000, 32'(b)} || s_wstrb !== strb || s_wlast !== (b == beats - 1)) begin
                n_errors++; $display("FAIL wr_w_fwd beat=%0d got=%b/%h/%h/%b", b, s_wvalid, s_wdata, s_wstrb, s_wlast);
            end
            n_checks++; if (m1_wready !== 1'b1 || m0_arready !== 1'b0 || m1_arready !== 1'b0) begin
                n_errors++; $display("FAIL wr_w_ready beat=%0d got=%b/%b/%b exp=1/0/0", b, m1_wready, m0_arready, m1_arready);
            end
            clk_step();
        end
        m1_wvalid = 0; m1_wlast = 0; s_wready = 0;
        n_checks++; if (dut.r_state !== ST_B) begin n_errors++; $display("FAIL wr_state_b got=%0d exp=%0d", dut.r_state, ST_B); end
        s_bvalid = 1; s_bresp = RESP_OKAY; s_bid = id; m1_bready = 1;
        #1;
        n_checks++; if (m1_bvalid !== 1'b1 || m1_bresp !== RESP_OKAY || m1_bid !== id || s_bready !== 1'b1) begin
            n_errors++; $display("FAIL wr_b got=%b/%b/%h/%b exp=1/00/%h/1", m1_bvalid, m1_bresp, m1_bid, s_bready, id);
        end
        clk_step();
        s_bvalid = 0; m1_bready = 0;
        n_checks++; if (dut.r_state !== ST_IDLE) begin n_errors++; $display("FAIL wr_done_idle got=%0d exp=%0d", dut.r_state, ST_IDLE); end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        m0_arvalid = 1; m1_awvalid = 1; s_rvalid = 1; s_bvalid = 1;
        repeat (2) clk_step();
        n_checks++; if (dut.r_state !== ST_IDLE) begin n_errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.r_state, ST_IDLE); end
        n_checks++; if (dut.r_last_grant !== 1'b0) begin n_errors++; $display("FAIL reset_last_grant got=%b exp=0", dut.r_last_grant); end
        n_checks++; if (any_out !== 1'b0) begin n_errors++; $display("FAIL reset_outputs got=%b exp=0", any_out); end
        clear_inputs();
        rst_n = 1;
        clk_step();
    endtask

    task automatic test_m0_read();
        do_read(0, 32'h8000_0000, 4'h3, 2, 0);
    endtask

    task automatic test_tie();
        m0_arvalid = 1; m0_araddr = 32'h8000_0300;
        do_read(1, 32'h8000_0200, 4'h1, 1, 0);
        n_checks++; if (dut.r_last_grant !== 1'b1) begin n_errors++; $display("FAIL tie_last_grant1 got=%b exp=1", dut.r_last_grant); end
        do_read(0, 32'h8000_0300, 4'h2, 1, 0);
        n_checks++; if (dut.r_last_grant !== 1'b0) begin n_errors++; $display("FAIL tie_last_grant0 got=%b exp=0", dut.r_last_grant); end
        m0_arvalid = 1; m0_araddr = 32'h8000_0400;
        do_read(1, 32'h8000_0500, 4'h4, 1, 0);
        m0_arvalid = 0;
    endtask

    task automatic test_write();
        do_write(32'h8000_0010, 4'h5, 2, 8'h0F);
    endtask

    task automatic test_aw_ar_priority();
        m1_arvalid = 1; m1_araddr = 32'h8000_0600; m1_arid = 4'h6;
        do_write(32'h8000_0020, 4'h7, 1, 8'hFF);
        do_read(1, 32'h8000_0600, 4'h6, 2, 0);
    endtask

    task automatic test_stall();
        do_read(0, 32'h8000_0100, 4'h9, 3, 5);
    endtask

    task automatic test_reset_mid();
        m1_arvalid = 1; m1_araddr = 32'h8000_0700; m1_arid = 4'hA; m1_arlen = 8'd3; m1_rready = 1;
        clk_step();
        s_arready = 1;
        clk_step();
        s_arready = 0; m1_arvalid = 0;
        n_checks++; if (dut.r_state !== ST_R1) begin n_errors++; $display("FAIL rst_mid_in_r1 got=%0d exp=%0d", dut.r_state, ST_R1); end
        s_rvalid = 1; s_rdata = 64'h1234; s_rlast = 0;
        #1;
        n_checks++; if (m1_rvalid !== 1'b1) begin n_errors++; $display("FAIL rst_mid_live_rvalid got=%b exp=1", m1_rvalid); end
        rst_n = 0;
        clk_step();
        n_checks++; if (dut.r_state !== ST_IDLE) begin n_errors++; $display("FAIL rst_mid_state got=%0d exp=%0d", dut.r_state, ST_IDLE); end
        n_checks++; if (any_out !== 1'b0) begin n_errors++; $display("FAIL rst_mid_outputs got=%b exp=0", any_out); end
        clear_inputs();
        rst_n = 1;
        clk_step();
        do_read(0, 32'h8000_0800, 4'hB, 2, 0);
    endtask

    initial begin
        test_reset();
        test_m0_read();
        test_tie();
        test_write();
        test_aw_ar_priority();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
